// File: rtl/mtm_alu_core_pipe_if.sv
// Handshake bundle for mtm_alu_core_pipe: upstream operation channel
// (A, B, opcode, input CRC) and downstream result channel (C, control byte).
interface mtm_alu_core_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [2:0]        in_op;
    logic [3:0]        in_crc;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_c;
    logic [7:0]        out_ctl;

    // Source side: frame deserializer feeding operations, serializer taking results.
    modport master (
        output in_valid, in_a, in_b, in_op, in_crc, out_ready,
        input  in_ready, out_valid, out_c, out_ctl
    );

    // Core side.
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_crc, out_ready,
        output in_ready, out_valid, out_c, out_ctl
    );
endinterface

// File: rtl/mtm_alu_core_pipe.sv
// Pipelined ALU core. S1 checks the input CRC4 / opcode and computes the
// result and flags; S2 builds the control byte (flags + CRC3, or an error
// frame) and holds it on the output until the consumer takes it.
module mtm_alu_core_pipe #(
    parameter int DATA_W   = 32,
    parameter int CRC_IN_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    mtm_alu_core_pipe_if.slave bus
);

    localparam int MSG4_W = 2 * DATA_W + 4;
    localparam int MSG3_W = DATA_W + 5;
    localparam int MSB    = DATA_W - 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    // CRC over x^4+x+1, MSB first, zero init.
    function automatic logic [CRC_IN_W-1:0] crc4(input logic [MSG4_W-1:0] msg);
        logic [CRC_IN_W-1:0] r;
        logic                fb;
        r = '0;
        for (int i = MSG4_W - 1; i >= 0; i--) begin
            fb = r[CRC_IN_W-1] ^ msg[i];
            r  = {r[CRC_IN_W-2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return r;
    endfunction

    // CRC over x^3+x+1, MSB first, zero init.
    function automatic logic [2:0] crc3(input logic [MSG3_W-1:0] msg);
        logic [2:0] r;
        logic       fb;
        r = '0;
        for (int i = MSG3_W - 1; i >= 0; i--) begin
            fb = r[2] ^ msg[i];
            r  = {r[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic run;
    logic s1_valid;
    logic s2_valid;
    logic s1_advance;
    logic s2_advance;
    logic in_fire;

    // in_ready is held low during reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run <= 1'b0;
        else     run <= 1'b1;
    end

    // S2 can take new data when empty or when its current word leaves this cycle;
    // S1 likewise when it is empty or moving into S2. out_ready reaches in_ready
    // combinationally so a full pipe still accepts one op per clock.
    assign s2_advance   = !s2_valid || bus.out_ready;
    assign s1_advance   = !s1_valid || s2_advance;
    assign bus.in_ready = run && s1_advance;
    assign in_fire      = bus.in_valid && bus.in_ready;

    // ---------------------------------------------------------------
    // S1 combinational: input check and arithmetic
    // ---------------------------------------------------------------
    logic [CRC_IN_W-1:0] crc_calc;
    logic                err_crc_d;
    logic                err_op_d;
    logic                op_ok;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   alu_c;
    logic                alu_carry;
    logic                alu_ovf;
    logic                alu_zero;
    logic                alu_neg;

    assign crc_calc  = crc4({bus.in_b, bus.in_a, 1'b1, bus.in_op});
    assign err_crc_d = (crc_calc != bus.in_crc);
    assign err_op_d  = !err_crc_d && !op_ok;

    // Result and carry/overflow per opcode; the extra top bit of sum/diff is
    // carry-out and borrow respectively.
    always_comb begin
        sum       = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        diff      = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        alu_c     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        op_ok     = 1'b1;
        case (bus.in_op)
            OP_AND: alu_c = bus.in_a & bus.in_b;
            OP_OR:  alu_c = bus.in_a | bus.in_b;
            OP_ADD: begin
                alu_c     = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
                alu_ovf   = (bus.in_a[MSB] == bus.in_b[MSB]) && (sum[MSB] != bus.in_a[MSB]);
            end
            OP_SUB: begin
                alu_c     = diff[DATA_W-1:0];
                alu_carry = diff[DATA_W];
                alu_ovf   = (bus.in_a[MSB] != bus.in_b[MSB]) && (diff[MSB] != bus.in_a[MSB]);
            end
            default: op_ok = 1'b0;
        endcase
    end

    assign alu_zero = (alu_c == '0);
    assign alu_neg  = alu_c[MSB];

    // ---------------------------------------------------------------
    // S1 register
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] s1_c;
    logic              s1_carry;
    logic              s1_ovf;
    logic              s1_zero;
    logic              s1_neg;
    logic              s1_err_crc;
    logic              s1_err_op;

    // Capture an accepted op; payload only changes on a real transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_c       <= '0;
            s1_carry   <= 1'b0;
            s1_ovf     <= 1'b0;
            s1_zero    <= 1'b0;
            s1_neg     <= 1'b0;
            s1_err_crc <= 1'b0;
            s1_err_op  <= 1'b0;
        end else if (s1_advance) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_c       <= alu_c;
                s1_carry   <= alu_carry;
                s1_ovf     <= alu_ovf;
                s1_zero    <= alu_zero;
                s1_neg     <= alu_neg;
                s1_err_crc <= err_crc_d;
                s1_err_op  <= err_op_d;
            end
        end
    end

    // ---------------------------------------------------------------
    // S2 combinational: control byte
    // ---------------------------------------------------------------
    logic [2:0]        crc3_calc;
    logic [2:0]        e3;
    logic [6:0]        err_body;
    logic              s1_err;
    logic [DATA_W-1:0] c_d;
    logic [7:0]        ctl_d;

    // Error frames zero the result and carry the error code twice plus an
    // even-parity bit; normal frames carry flags and CRC3 of {C, flags}.
    always_comb begin
        crc3_calc = crc3({s1_c, 1'b0, s1_carry, s1_ovf, s1_zero, s1_neg});
        e3        = {1'b0, s1_err_crc, s1_err_op};
        err_body  = {1'b1, e3, e3};
        s1_err    = s1_err_crc || s1_err_op;
        if (s1_err) begin
            c_d   = '0;
            ctl_d = {err_body, ^err_body};
        end else begin
            c_d   = s1_c;
            ctl_d = {1'b0, s1_carry, s1_ovf, s1_zero, s1_neg, crc3_calc};
        end
    end

    // ---------------------------------------------------------------
    // S2 / output register
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] out_c_q;
    logic [7:0]        out_ctl_q;

    // Output word is only rewritten when S1 delivers, so it holds through stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_c_q   <= '0;
            out_ctl_q <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_c_q   <= c_d;
                out_ctl_q <= ctl_d;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_c     = out_c_q;
    assign bus.out_ctl   = out_ctl_q;

endmodule

// File: tb/tb_mtm_alu_core_pipe.sv
// Scoreboard bench for mtm_alu_core_pipe: a 32-bit instance driven with
// directed and random ops, plus an 8-bit instance for the narrow-width case.
module tb_mtm_alu_core_pipe;

    localparam int W  = 32;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mtm_alu_core_pipe_if #(.DATA_W(W))  bus  ();
    mtm_alu_core_pipe_if #(.DATA_W(W8)) bus8 ();

    mtm_alu_core_pipe #(.DATA_W(W),  .CRC_IN_W(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mtm_alu_core_pipe #(.DATA_W(W8), .CRC_IN_W(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    bit     lat_chk  = 1'b0;

    typedef struct {
        logic [63:0] c;
        logic [7:0]  ctl;
        longint      acc;
        bit          kchk;
        logic [63:0] kc;
        logic [7:0]  kctl;
        logic [7:0]  kmask;
    } exp_t;

    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Remainder of msg(x) * x^deg divided by gen(x), over GF(2).
    function automatic logic [7:0] poly_rem(input logic [127:0] msg, input int nbits,
                                            input logic [4:0] gen, input int deg);
        logic [135:0] v;
        v = {8'b0, msg} << deg;
        for (int i = nbits + deg - 1; i >= deg; i--)
            if (v[i]) v = v ^ ({131'b0, gen} << (i - deg));
        return v[7:0] & 8'((1 << deg) - 1);
    endfunction

    function automatic logic [3:0] crc_in(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op);
        logic [127:0] m;
        logic [7:0]   r;
        m = ({64'b0, b} << (w + 4)) | ({64'b0, a} << 4) | 128'h8 | {125'b0, op};
        r = poly_rem(m, 2 * w + 4, 5'b10011, 4);
        return r[3:0];
    endfunction

    function automatic longint to_signed(input int w, input logic [63:0] x);
        return x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    endfunction

    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] op, input logic [3:0] crc,
                                  output logic [63:0] c, output logic [7:0] ctl);
        logic [2:0]   e3;
        logic [63:0]  s;
        logic [127:0] m;
        logic [7:0]   r3;
        logic         cy, ov, z, n;
        longint       sr, lo, hi;
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        if (crc_in(w, a, b, op) != crc)          e3 = 3'b010;
        else if (!(op inside {3'd0, 3'd1, 3'd4, 3'd5})) e3 = 3'b001;
        else                                      e3 = 3'b000;
        if (e3 != 3'b000) begin
            c      = 64'd0;
            ctl    = {1'b1, e3, e3, 1'b0};
            ctl[0] = ^ctl[7:1];
            return;
        end
        c = 64'd0; cy = 1'b0; ov = 1'b0;
        case (op)
            3'd0: c = a & b;
            3'd1: c = a | b;
            3'd4: begin
                s  = a + b;
                c  = s & mask(w);
                cy = (s >> w) != 64'd0;
                sr = to_signed(w, a) + to_signed(w, b);
                ov = (sr > hi) || (sr < lo);
            end
            default: begin
                c  = (a - b) & mask(w);
                cy = a < b;
                sr = to_signed(w, a) - to_signed(w, b);
                ov = (sr > hi) || (sr < lo);
            end
        endcase
        z   = (c == 64'd0);
        n   = c[w-1];
        m   = ({64'b0, c} << 5) | {123'b0, 1'b0, cy, ov, z, n};
        r3  = poly_rem(m, w + 5, 5'b01011, 3);
        ctl = {1'b0, cy, ov, z, n, r3[2:0]};
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the op is transferred.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        input bit bad, input bit kchk, input logic [63:0] kc,
                        input logic [7:0] kctl, input logic [7:0] kmask);
        exp_t        e;
        logic [3:0]  crc;
        logic [63:0] ec;
        logic [7:0]  ectl;
        int          waited;
        bit          ok;
        crc = crc_in(W, a, b, op);
        if (bad) crc = crc ^ 4'($urandom_range(1, 15));
        model(W, a, b, op, crc, ec, ectl);
        e.c = ec; e.ctl = ectl; e.kchk = kchk; e.kc = kc; e.kctl = kctl; e.kmask = kmask;
        bus.in_a     = a[W-1:0];
        bus.in_b     = b[W-1:0];
        bus.in_op    = op;
        bus.in_crc   = crc;
        bus.in_valid = 1'b1;
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited < 64) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else waited++;
        end
        if (ok) begin
            e.acc = cyc;
            sb.push_back(e);
        end else begin
            check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb.size() != 0 && n < 100);
        #1;
        check("scoreboard_drain", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF;
            2:       return 64'h8000_0000;
            3:       return 64'h7FFF_FFFF;
            default: return 64'($urandom);
        endcase
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = sb[0];
                    check("out_c", 64'(bus.out_c), e.c);
                    check("out_ctl", 64'(bus.out_ctl), 64'(e.ctl));
                    if (e.kchk) begin
                        check("out_c_const", 64'(bus.out_c), e.kc);
                        check("out_ctl_const", 64'(bus.out_ctl & e.kmask), 64'(e.kctl));
                    end
                    if (bus.out_ready) begin
                        if (lat_chk) check("latency", 64'(cyc - e.acc), 64'd2);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- narrow instance ----------------
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] kc, input logic [7:0] kctl, input logic [7:0] kmask);
        logic [63:0] ec;
        logic [7:0]  ectl;
        logic [3:0]  crc;
        int          n;
        bit          seen;
        crc = crc_in(W8, {56'b0, a}, {56'b0, b}, op);
        model(W8, {56'b0, a}, {56'b0, b}, op, crc, ec, ectl);
        bus8.in_a = a; bus8.in_b = b; bus8.in_op = op; bus8.in_crc = crc;
        bus8.in_valid = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 16) begin
            @(negedge clk);
            if (bus8.in_ready) seen = 1'b1;
            else n++;
        end
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 16) begin
            @(negedge clk);
            if (bus8.out_valid) seen = 1'b1;
            else n++;
        end
        check("dut8_out_valid", 64'(bus8.out_valid), 64'd1);
        if (seen) begin
            check("dut8_out_c", 64'(bus8.out_c), ec);
            check("dut8_out_c_const", 64'(bus8.out_c), 64'(kc));
            check("dut8_out_ctl", 64'(bus8.out_ctl), 64'(ectl));
            check("dut8_ctl_const", 64'(bus8.out_ctl & kmask), 64'(kctl));
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd4, 3'd5};

    initial begin
        bit done;
        bus.in_valid  = 1'b0; bus.in_a  = '0; bus.in_b  = '0; bus.in_op  = '0; bus.in_crc  = '0;
        bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_op = '0; bus8.in_crc = '0;
        bus8.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_c", 64'(bus.out_c), 64'd0);
        check("rst_out_ctl", 64'(bus.out_ctl), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Directed cases with out_ready held high.
        lat_chk = 1'b1;
        send(64'h7FFF_FFFF, 64'h1, 3'b100, 0, 1, 64'h8000_0000, 8'b0010_1000, 8'hF8);
        send(64'hFFFF_FFFF, 64'h1, 3'b100, 0, 1, 64'h0,         8'b0101_0000, 8'hF8);
        send(64'h0,         64'h1, 3'b101, 0, 1, 64'hFFFF_FFFF, 8'b0100_1000, 8'hF8);
        send(64'hF0F0_0000, 64'h0F0F_0000, 3'b000, 0, 1, 64'h0,         8'b0001_0000, 8'hF8);
        send(64'hF0F0_0000, 64'h0F0F_0000, 3'b001, 0, 1, 64'hFFFF_0000, 8'b0000_1000, 8'hF8);
        send(64'h1234_5678, 64'h9ABC_DEF0, 3'b011, 0, 1, 64'h0, 8'h93, 8'hFF);
        send(64'h1234_5678, 64'h9ABC_DEF0, 3'b100, 1, 1, 64'h0, 8'hA5, 8'hFF);
        send(64'h1234_5678, 64'h9ABC_DEF0, 3'b011, 1, 1, 64'h0, 8'hA5, 8'hFF);
        for (int i = 0; i < 8; i++)
            send(pick(), pick(), ops[i % 4], 0, 0, 64'h0, 8'h0, 8'h0);
        drain();

        // Stall: four back-to-back ops against a blocked consumer for five clocks.
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(pick(), pick(), ops[$urandom_range(0, 3)], 0, 0, 64'h0, 8'h0, 8'h0);
            end
            begin
                repeat (3) @(negedge clk);
                check("stall_in_ready_low", 64'(bus.in_ready), 64'd0);
                check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("release_one_per_clk", 64'(bus.out_valid), 64'd1);
                end
            end
        join
        drain();

        // Random traffic with a randomly stalling consumer.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(pick(), pick(),
                         ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 3)] : 3'($urandom),
                         $urandom_range(0, 6) == 0, 0, 64'h0, 8'h0, 8'h0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset while two ops are in flight.
        send(pick(), pick(), 3'b100, 0, 0, 64'h0, 8'h0, 8'h0);
        send(pick(), pick(), 3'b101, 0, 0, 64'h0, 8'h0, 8'h0);
        #1;
        check("inflight_before_rst", 64'(bus.out_valid), 64'd1);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_midrst", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_after_rst", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(64'h7FFF_FFFF, 64'h1, 3'b100, 0, 1, 64'h8000_0000, 8'b0010_1000, 8'hF8);
        drain();

        // Narrow instance.
        run8(8'h7F, 8'h01, 3'b100, 8'h80, 8'b0010_1000, 8'hF8);
        run8(8'h00, 8'h01, 3'b101, 8'hFF, 8'b0100_1000, 8'hF8);
        run8(8'h5A, 8'hC3, 3'b111, 8'h00, 8'h93,        8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
